// File: rtl/instr_mem_if.sv
// -----------------------------------------------------------------------------
// instr_mem_if
//   Bundles the instruction-memory buses: the fetch-stage read port and the
//   host boot-load port. Signal suffixes (_i/_o) are relative to the memory.
//
//   Fetch read : im_addr_i, im_rd_i -> im_data_o, im_valid_o
//   Host load  : load_start_i, load_valid_i, load_data_i, load_last_i
//                -> load_ready_o, load_done_o, load_err_o, load_count_o
//   Boot       : start_o (one-cycle pulse to the fetch stage)
//
//   slave  : the memory itself
//   master : the fetch stage / host side (used by the testbench)
// -----------------------------------------------------------------------------
interface instr_mem_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] im_addr_i;
    logic                  im_rd_i;
    logic [DATA_WIDTH-1:0] im_data_o;
    logic                  im_valid_o;

    logic                  load_start_i;
    logic                  load_valid_i;
    logic [DATA_WIDTH-1:0] load_data_i;
    logic                  load_last_i;
    logic                  load_ready_o;
    logic                  load_done_o;
    logic                  load_err_o;
    logic [ADDR_WIDTH:0]   load_count_o;
    logic                  start_o;

    modport slave (
        input  im_addr_i, im_rd_i,
        output im_data_o, im_valid_o,
        input  load_start_i, load_valid_i, load_data_i, load_last_i,
        output load_ready_o, load_done_o, load_err_o, load_count_o, start_o
    );

    modport master (
        output im_addr_i, im_rd_i,
        input  im_data_o, im_valid_o,
        output load_start_i, load_valid_i, load_data_i, load_last_i,
        input  load_ready_o, load_done_o, load_err_o, load_count_o, start_o
    );
endinterface

// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
//   Instruction memory for the 16-bit pipelined processor. The host streams a
//   program in over a valid/ready port; once the load completes, the fetch
//   stage reads it with a registered one-cycle latency. Reads at or beyond
//   the loaded word count return 0 (NOP). A successful load pulses start_o.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : instr_mem_if.slave (fetch read port + host load port)
// -----------------------------------------------------------------------------
module instr_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    instr_mem_if.slave   bus
);
    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_load_ready;
    logic                  w_accept;
    logic                  w_at_end;
    logic                  w_rd_hit;

    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_done;
    logic                  r_err;
    logic                  r_start;
    logic [DATA_WIDTH-1:0] r_im_data;
    logic                  r_im_valid;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // A restart in the same cycle as a valid word wins: the word is dropped.
    assign w_accept = bus.load_valid_i & w_load_ready & ~bus.load_start_i;
    assign w_at_end = (r_count == LAST_IDX);
    // Compare one bit wider so count == DEPTH (after overflow) covers every address.
    assign w_rd_hit = ({1'b0, bus.im_addr_i} < r_count);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves w_next_state unassigned
    // (otherwise a latch is inferred).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.load_start_i) w_next_state = LOAD;
            end
            LOAD: begin
                if (bus.load_start_i)                           w_next_state = LOAD;
                else if (w_accept && (bus.load_last_i || w_at_end)) w_next_state = READY;
            end
            READY: begin
                if (bus.load_start_i) w_next_state = LOAD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_load_ready = (r_state == LOAD);
    end

    // Load bookkeeping and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_im_data  <= '0;
            r_im_valid <= 1'b0;
        end else begin
            r_start <= 1'b0;

            // load_start_i always (re)enters LOAD, from any state.
            if (bus.load_start_i) begin
                r_count <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                r_count <= r_count + ONE;
                if (bus.load_last_i) begin
                    r_done  <= 1'b1;
                    r_start <= 1'b1;
                end else if (w_at_end) begin
                    r_err <= 1'b1;
                end
            end

            // Fetch only sees data once a load has finished.
            if (r_state == READY) begin
                r_im_valid <= bus.im_rd_i;
                if (bus.im_rd_i) begin
                    r_im_data <= w_rd_hit ? r_mem[bus.im_addr_i] : '0;
                end
            end else begin
                r_im_valid <= 1'b0;
                r_im_data  <= '0;
            end
        end
    end

    // Program storage.
    // NOTE: the array has no reset; r_count gates every read, so stale
    // contents are never visible and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_count[ADDR_WIDTH-1:0]] <= bus.load_data_i;
        end
    end

    assign bus.load_ready_o = w_load_ready;
    assign bus.load_done_o  = r_done;
    assign bus.load_err_o   = r_err;
    assign bus.load_count_o = r_count;
    assign bus.start_o      = r_start;
    assign bus.im_data_o    = r_im_data;
    assign bus.im_valid_o   = r_im_valid;
endmodule

// File: doc/instr_mem.md
# instr_mem

Instruction memory responder for the 16-bit pipelined processor: it serves the fetch stage's instruction-read requests (`im_addr`/`im_rd`) with a registered one-cycle read. It also owns a host boot-load port that streams the program in with a valid/ready handshake. On successful load it pulses `start_o`, which drives the fetch stage's `start` input. Reads outside the loaded range return 0 (NOP), so fetch behaviour is deterministic.

## Interface
- `DATA_WIDTH`, 16, instruction word width
- `ADDR_WIDTH`, 8, address width; depth = 2**ADDR_WIDTH words
- `clk`  input  1  clock; all state updates on rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `im_addr_i`  input  ADDR_WIDTH  fetch address (current PC)
- `im_rd_i`  input  1  read request
- `im_data_o`  output  DATA_WIDTH  registered instruction
- `im_valid_o`  output  1  `im_data_o` carries a response to the previous cycle's request
- `load_start_i`  input  1  begin (or restart) a program load
- `load_valid_i`  input  1  host word valid
- `load_data_i`  input  DATA_WIDTH  host word
- `load_last_i`  input  1  qualifies final word of program
- `load_ready_o`  output  1  block accepts a host word this cycle
- `load_done_o`  output  1  program loaded successfully, sticky
- `load_err_o`  output  1  load overflowed depth, sticky
- `load_count_o`  output  ADDR_WIDTH+1  number of words loaded
- `start_o`  output  1  one-cycle pulse on successful load completion

## Operation
- FSM states: IDLE, LOAD, READY.
- Reset (`rst_n`=0, asynchronous):
  - State is IDLE.
  - All outputs and the count are 0.
  - The memory array is not cleared.
- Transitions:
  - IDLE→LOAD on `load_start_i`.
  - LOAD→READY on accepting a word with `load_last_i`=1, or on accepting a word at count = depth-1.
  - READY→LOAD on `load_start_i`.
  - `load_start_i` in LOAD restarts the load.
- Entering LOAD:
  - Count is cleared to 0.
  - `load_done_o` and `load_err_o` are cleared.
- `load_ready_o` = (state==LOAD). It is combinational from state, so it is low in the cycle `load_start_i` is sampled from IDLE or READY.
- Accept = `load_valid_i` & `load_ready_o`. On accept:
  - `mem[count]` ← `load_data_i`.
  - count ← count+1.
- Host holds `load_data_i` and `load_last_i` stable while `load_valid_i`=1 and `load_ready_o`=0.
- Successful completion: last word accepted with `load_last_i`=1, at any count up to depth-1.
  - Next cycle: state READY, `load_done_o`=1.
  - `start_o`=1 for exactly that one cycle.
- Overflow: word accepted at count = depth-1 with `load_last_i`=0.
  - The word is written and count becomes depth.
  - State READY, `load_err_o`=1, `load_done_o`=0.
  - No `start_o` pulse.
- `load_start_i` and `load_valid_i` in the same LOAD cycle: restart wins. The data is not written and count goes to 0.
- Read path, READY state:
  - `im_rd_i`=1 at edge N → at N+1, `im_valid_o`=1 and `im_data_o` = (`im_addr_i` < count) ? `mem[im_addr_i]` : 0.
  - Compare in ADDR_WIDTH+1 bits.
- Read path, `im_rd_i`=0 in READY: `im_valid_o`=0 and `im_data_o` holds its last value.
- Read path, IDLE or LOAD: `im_valid_o`=0 and `im_data_o`=0 regardless of `im_rd_i`. Fetch never observes a partially loaded program.
- Read address and write pointer are independent; there is no read during a write in READY.

## Timing
- Read latency 1 cycle: address sampled at edge N, data valid after edge N+1. This aligns with the fetch stage's IF/ID register capture.
- Sustained throughput is one read per cycle; back-to-back addresses return in order.
- Load throughput is one word per cycle while `load_valid_i` is held high.
- `start_o` pulse rises at the edge after the last word is accepted and falls one cycle later.
- `load_done_o` and `load_err_o` hold until the next LOAD entry or reset.
- `load_count_o` updates at the edge of each accept.
- Reset mid-load: outputs drop asynchronously to 0 and the FSM returns to IDLE. A subsequent read returns nothing until a full reload, because count is 0.

## Test plan
- Reset then load: `load_start_i`, stream words 0x1111, 0x2222, 0x3333 with `last` on the third.
  - `load_count_o`=3 and `load_done_o`=1.
  - `start_o` high for exactly 1 cycle.
- Fetch after load: `im_rd_i`=1 with addresses 0,1,2,3 on consecutive cycles.
  - One cycle later each: 0x1111, 0x2222, 0x3333, then 0x0000.
  - `im_valid_o`=1 on all four.
- Host stall: toggle `load_valid_i` 1,0,1,0,1 (last on third valid).
  - Exactly 3 words written and count=3.
  - No writes on the idle cycles.
- Overflow: stream 256 words with `last` never set.
  - State READY, count=256, `load_err_o`=1, `load_done_o`=0.
  - No `start_o` pulse.
  - Read of address 255 returns the 256th word.
- Restart and collision: mid-load at count=5, assert `load_start_i` with `load_valid_i` in the same cycle.
  - Count goes to 0 and that word is not written.
  - While in LOAD, reads give `im_valid_o`=0.
- Async reset: drop `rst_n` mid-load between clock edges.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, `im_rd_i`=1 yields `im_valid_o`=0 until a reload completes.
